// File: rtl/spectrum_readout_ctrl.sv
// Histogram RAM arbiter and spectrum readout controller for the MCA.
// Shares one single-port RAM between per-event bin increments and a host
// readout that streams every bin as two bytes (high byte first). Optional
// clear-on-read zeroes each bin right after its count has been latched.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | no RAM traffic; arbitrate increment vs. pending readout
// S_INC_RD | present inc_addr to RAM, acknowledge the increment
// S_INC_WR | write back saturated count+1 to the registered address
// S_RO_RD  | present readout index to RAM
// S_RO_LAT | latch RAM data into word; write zero in clear mode
// S_TX_HI  | offer word[15:8] to the transmitter
// S_TX_LO  | offer word[7:0]; word boundary, advance or finish

module spectrum_readout_ctrl #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              clear_after,
   output logic              busy,
   output logic              done,
   input  logic              inc_req,
   input  logic [ADDR_W-1:0] inc_addr,
   output logic              inc_ack,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [15:0]       ram_wdata,
   input  logic [15:0]       ram_rdata,
   output logic [7:0]        tx_byte,
   output logic              tx_valid,
   input  logic              tx_ready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INC_RD,
      S_INC_WR,
      S_RO_RD,
      S_RO_LAT,
      S_TX_HI,
      S_TX_LO
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] inc_addr_q;
   logic [15:0]       word;
   logic              start_pending;
   logic              clear_mode;

   // A start is only taken when no readout is running or queued.
   logic start_acc;
   logic ro_req;
   logic last_bin;
   logic lo_fire;
   logic dump_end;

   assign start_acc = start && !busy && !start_pending;
   assign ro_req    = start_pending || start_acc;
   assign last_bin  = (idx == '1);
   assign lo_fire   = (state == S_TX_LO) && tx_ready;
   assign dump_end  = lo_fire && last_bin;

   // Next-state and Moore/Mealy outputs; RAM port is idle unless a state drives it.
   always_comb begin
      state_nxt = state;
      inc_ack   = 1'b0;
      ram_addr  = '0;
      ram_we    = 1'b0;
      ram_wdata = 16'h0000;
      tx_byte   = 8'h00;
      tx_valid  = 1'b0;
      case (state)
         S_IDLE: begin
            if (inc_req)
               state_nxt = S_INC_RD;
            else if (ro_req)
               state_nxt = S_RO_RD;
         end
         S_INC_RD: begin
            ram_addr  = inc_addr;
            inc_ack   = 1'b1;
            state_nxt = S_INC_WR;
         end
         S_INC_WR: begin
            ram_addr  = inc_addr_q;
            ram_we    = 1'b1;
            ram_wdata = (ram_rdata == 16'hFFFF) ? 16'hFFFF : ram_rdata + 16'd1;
            // A running readout resumes first so one increment per word is the limit.
            if (busy)
               state_nxt = S_RO_RD;
            else if (inc_req)
               state_nxt = S_INC_RD;
            else
               state_nxt = S_IDLE;
         end
         S_RO_RD: begin
            ram_addr  = idx;
            state_nxt = S_RO_LAT;
         end
         S_RO_LAT: begin
            if (clear_mode) begin
               ram_addr  = idx;
               ram_we    = 1'b1;
               ram_wdata = 16'h0000;
            end
            state_nxt = S_TX_HI;
         end
         S_TX_HI: begin
            tx_valid = 1'b1;
            tx_byte  = word[15:8];
            if (tx_ready)
               state_nxt = S_TX_LO;
         end
         S_TX_LO: begin
            tx_valid = 1'b1;
            tx_byte  = word[7:0];
            if (tx_ready) begin
               if (last_bin)
                  state_nxt = S_IDLE;
               else if (inc_req)
                  state_nxt = S_INC_RD;
               else
                  state_nxt = S_RO_RD;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Readout bookkeeping: request capture, bin index, busy/done flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_pending <= 1'b0;
         clear_mode    <= 1'b0;
         idx           <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         done <= dump_end;
         if (start_acc) begin
            clear_mode <= clear_after;
            idx        <= '0;
            busy       <= 1'b1;
         end else if (dump_end) begin
            busy <= 1'b0;
         end else if (lo_fire) begin
            idx <= idx + ADDR_W'(1);
         end
         // Pending only bridges the gap until the first bin read starts.
         if (state_nxt == S_RO_RD)
            start_pending <= 1'b0;
         else if (start_acc)
            start_pending <= 1'b1;
      end
   end

   // Data capture: increment address and the word being transmitted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inc_addr_q <= '0;
         word       <= 16'h0000;
      end else begin
         if (state == S_INC_RD)
            inc_addr_q <= inc_addr;
         if (state == S_RO_LAT)
            word <= ram_rdata;
      end
   end

endmodule

// File: tb/tb_spectrum_readout_ctrl.sv
// Bench for spectrum_readout_ctrl: synchronous RAM model, expected-byte
// scoreboard built from a bin-level reference model, negedge monitor.

module tb_spectrum_readout_ctrl;

   localparam int AW = 2;
   localparam int NB = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          clear_after = 1'b0;
   logic          inc_req = 1'b0;
   logic [AW-1:0] inc_addr = '0;
   logic          tx_ready = 1'b0;
   logic          busy, done, inc_ack, ram_we, tx_valid;
   logic [AW-1:0] ram_addr;
   logic [15:0]   ram_wdata;
   logic [15:0]   ram_rdata;
   logic [7:0]    tx_byte;

   int checks = 0;
   int errors = 0;

   logic [15:0]   mem     [NB];
   logic [15:0]   ref_mem [NB];
   logic          load_en = 1'b0;
   logic [AW-1:0] load_addr = '0;
   logic [15:0]   load_data = 16'h0;

   logic [7:0] exp_q [$];
   logic [7:0] mon_b;
   int         done_cnt = 0;
   bit         stall_prev = 0;
   logic [7:0] prev_byte = 8'h0;
   bit         stall_mode = 0;

   always #5 clk = ~clk;

   spectrum_readout_ctrl #(.ADDR_W(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .clear_after(clear_after),
      .busy       (busy),
      .done       (done),
      .inc_req    (inc_req),
      .inc_addr   (inc_addr),
      .inc_ack    (inc_ack),
      .ram_addr   (ram_addr),
      .ram_we     (ram_we),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata),
      .tx_byte    (tx_byte),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready)
   );

   // Single-port RAM, read data one cycle after the address.
   always @(posedge clk) begin
      if (load_en)
         mem[load_addr] <= load_data;
      else if (ram_we)
         mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Transmitter side: ready always or roughly one cycle in three.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         tx_ready = stall_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
      end
   end

   // Monitor: every accepted byte is popped against the scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 0;
      end else begin
         if (stall_prev)
            chk("tx_hold", {23'h0, tx_valid, tx_byte}, {23'h0, 1'b1, prev_byte});
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL tx_unexpected actual=%0h required=none", tx_byte);
            end else begin
               mon_b = exp_q.pop_front();
               chk("tx_byte", {24'h0, tx_byte}, {24'h0, mon_b});
            end
         end
         if (done) begin
            done_cnt++;
            chk("done_busy_low", {31'h0, busy}, 32'h0);
         end
         stall_prev = tx_valid && !tx_ready;
         prev_byte  = tx_byte;
      end
   end

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Reference: each bin read in order, cleared if requested, then one
   // pending increment lands at that word boundary.
   task automatic expect_dump(input bit clr, input int n_inc, input int a);
      int left;
      left = n_inc;
      for (int i = 0; i < NB; i++) begin
         exp_q.push_back(ref_mem[i][15:8]);
         exp_q.push_back(ref_mem[i][7:0]);
         if (clr) ref_mem[i] = 16'h0000;
         if (left > 0) begin
            ref_mem[a] = sat_inc(ref_mem[a]);
            left--;
         end
      end
   endtask

   task automatic chk_reset_outs(input string name);
      chk(name, {1'b0, busy, done, inc_ack, ram_we, tx_valid, ram_addr, ram_wdata, tx_byte}, 32'h0);
   endtask

   task automatic load_ram();
      for (int i = 0; i < NB; i++) begin
         load_en   = 1'b1;
         load_addr = AW'(i);
         load_data = ref_mem[i];
         @(posedge clk);
         #1;
      end
      load_en = 1'b0;
   endtask

   task automatic chk_ram();
      for (int i = 0; i < NB; i++)
         chk($sformatf("ram_bin%0d", i), {16'h0, mem[i]}, {16'h0, ref_mem[i]});
   endtask

   task automatic do_incs(input int a, input int n, input bit chk_gap);
      int acks;
      int last;
      int cyc;
      acks = 0;
      last = 0;
      cyc  = 0;
      inc_addr = AW'(a);
      inc_req  = 1'b1;
      while (acks < n && cyc < 600) begin
         if (inc_ack) begin
            if (chk_gap && acks > 0) chk("ack_gap", cyc - last, 2);
            chk("ack_addr", {30'h0, ram_addr}, a);
            last = cyc;
            acks++;
         end
         @(posedge clk);
         #1;
         cyc++;
         if (acks == n) inc_req = 1'b0;
      end
      if (acks < n) chk("inc_timeout", acks, n);
      inc_req = 1'b0;
   endtask

   task automatic run_dump(input bit clr, input int n_inc, input int a, input bit stall,
                           input bit spur, output int first_v, output int done_c);
      int d0;
      int fv;
      int dc;
      expect_dump(clr, n_inc, a);
      stall_mode  = stall;
      d0          = done_cnt;
      fv          = -1;
      dc          = -1;
      start       = 1'b1;
      clear_after = clr;
      @(posedge clk);
      #1;
      start       = 1'b0;
      clear_after = 1'b0;
      chk("busy_rise", {31'h0, busy}, 32'h1);
      fork
         begin
            for (int c = 1; c < 600 && dc < 0; c++) begin
               if (tx_valid && fv < 0) fv = c;
               if (done) dc = c;
               start = (spur && c == 6);
               if (dc < 0) begin
                  @(posedge clk);
                  #1;
               end
            end
            start = 1'b0;
            if (dc < 0) chk("done_timeout", 0, 1);
         end
         begin
            if (n_inc > 0) do_incs(a, n_inc, 1'b0);
         end
      join
      stall_mode = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      chk("no_restart", {31'h0, busy}, 32'h0);
      chk("done_count", done_cnt - d0, 1);
      chk("queue_drained", exp_q.size(), 0);
      chk_ram();
      first_v = fv;
      done_c  = dc;
   endtask

   initial begin
      int fv;
      int dc;
      int r;

      #3;
      chk_reset_outs("reset_outs");
      ref_mem = '{16'h0001, 16'h1234, 16'hFFFF, 16'h0000};
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      load_ram();

      // Plain dump, ready always high.
      run_dump(1'b0, 0, 0, 1'b0, 1'b0, fv, dc);
      chk("first_valid_cycle", fv, 3);
      chk("done_cycle", dc, 17);

      // Clear-on-read dump.
      ref_mem = '{16'h0001, 16'h1234, 16'hFFFF, 16'h0000};
      load_ram();
      run_dump(1'b1, 0, 0, 1'b0, 1'b0, fv, dc);
      chk("clear_done_cycle", dc, 17);

      // Idle increments into saturation, back to back.
      ref_mem = '{16'h0001, 16'h1234, 16'hFFFE, 16'h0000};
      load_ram();
      do_incs(2, 2, 1'b1);
      ref_mem[2] = sat_inc(sat_inc(ref_mem[2]));
      do_incs(0, 1, 1'b1);
      ref_mem[0] = sat_inc(ref_mem[0]);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk_ram();

      // Readout with an increment request held on bin 3.
      ref_mem = '{16'h0001, 16'h1234, 16'hFFFF, 16'h0007};
      load_ram();
      run_dump(1'b0, 4, 3, 1'b0, 1'b0, fv, dc);
      chk("inc_done_cycle", dc, 23);

      // Stalled transmitter plus a start while busy.
      ref_mem = '{16'h0001, 16'h1234, 16'hFFFF, 16'h0000};
      load_ram();
      run_dump(1'b0, 0, 0, 1'b1, 1'b1, fv, dc);
      chk("stall_first_valid", fv, 3);

      // Reset while the low byte of word 0 is on offer.
      ref_mem = '{16'hA55A, 16'h1234, 16'hFFFF, 16'h0000};
      load_ram();
      exp_q.push_back(ref_mem[0][15:8]);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("pre_rst_hi", {23'h0, tx_valid, tx_byte}, {23'h0, 1'b1, ref_mem[0][15:8]});
      @(posedge clk);
      #1;
      chk("pre_rst_lo", {23'h0, tx_valid, tx_byte}, {23'h0, 1'b1, ref_mem[0][7:0]});
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outs("reset_mid_tx");
      chk("rst_queue", exp_q.size(), 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_dump(1'b0, 0, 0, 1'b0, 1'b0, fv, dc);
      chk("post_rst_done", dc, 17);

      // Randomized dumps with random clear, increments and stalls.
      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < NB; i++) begin
            r = $urandom_range(0, 3);
            ref_mem[i] = (r == 0) ? 16'hFFFF : (r == 1) ? 16'hFFFE : 16'($urandom);
         end
         load_ram();
         run_dump(bit'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 3),
                  bit'($urandom_range(0, 1)), 1'b0, fv, dc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
